// File: rtl/ex_flag_stage_pkg.sv
// Shared ALU opcode / condition-code definitions and opcode class helpers.
// Used by the EX flag stage and the branch unit.
package ca2ca_defs;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // TST/TEQ/CMP/CMN only produce flags
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    return (!op[3] && (op[2:1] != 2'b00)) || (op[3:1] == 3'b101);
  endfunction

endpackage

// File: rtl/ex_flag_stage_cond_eval.sv
// Combinational condition-code evaluation against {N,Z,C,V}.
// Shared with the branch unit.
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  import ca2ca_defs::*;

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX back end: condition check, NZCV update and EX/MEM register with valid/ready.
// Optional perf counters enabled by defining EX_PERF_CNT_EN.
module ex_flag_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
`ifdef EX_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              flush,
  input  logic [3:0]        ex_cond,
  input  logic              ex_s,
  input  logic [3:0]        ex_op,
  input  logic              ex_wb_en,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              sh_carry,
  input  logic [DATA_W-1:0] alu_s,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic              alu_carry,
  output logic              cond_pass,
  output logic [3:0]        nzcv,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_wb_en
`ifdef EX_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_exec
  , output logic [CNT_W-1:0] perf_skip
`endif
);
  import ca2ca_defs::*;

  logic accept, exec;

  // Condition sees only the registered flags, so no alu_* -> cond_pass path exists
  cond_eval u_cond_eval (
    .cond (ex_cond),
    .nzcv (nzcv),
    .pass (cond_pass)
  );

  assign ex_ready  = !mem_valid || mem_ready;
  assign accept    = ex_valid && ex_ready && !flush;
  assign exec      = accept && cond_pass;
  assign alu_carry = nzcv[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv <= 4'b0000;
    end else if (exec && ex_s) begin
      nzcv[3] <= alu_n;
      nzcv[2] <= alu_z;
      if (is_arith_op(ex_op)) begin
        nzcv[1] <= alu_c;
        nzcv[0] <= alu_v;
      end else begin
        nzcv[1] <= sh_carry;
      end
    end
  end

  // Flush wins over a stall: the EX/MEM slot is emptied and nothing writes back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_rd     <= '0;
      mem_wb_en  <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      mem_wb_en <= 1'b0;
    end else if (ex_ready) begin
      mem_valid  <= exec;
      mem_result <= alu_s;
      mem_rd     <= ex_rd;
      mem_wb_en  <= ex_wb_en && !is_test_op(ex_op);
    end
  end

`ifdef EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_exec <= '0;
      perf_skip <= '0;
    end else begin
      if (exec)
        perf_exec <= perf_exec + 1'b1;
      if (accept && !cond_pass)
        perf_skip <= perf_skip + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage; perf-counter checks only when EX_PERF_CNT_EN is defined.
module tb_ex_flag_stage;
  import ca2ca_defs::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid, ex_ready, flush;
  logic [3:0]        ex_cond, ex_op, nzcv;
  logic              ex_s, ex_wb_en, sh_carry;
  logic [REG_W-1:0]  ex_rd, mem_rd;
  logic [DATA_W-1:0] alu_s, mem_result;
  logic              alu_n, alu_z, alu_c, alu_v;
  logic              alu_carry, cond_pass, mem_valid, mem_ready, mem_wb_en;
`ifdef EX_PERF_CNT_EN
  logic [3:0]        perf_exec, perf_skip;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_flag_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W)
`ifdef EX_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
    .ex_cond(ex_cond), .ex_s(ex_s), .ex_op(ex_op), .ex_wb_en(ex_wb_en), .ex_rd(ex_rd),
    .sh_carry(sh_carry), .alu_s(alu_s), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .alu_v(alu_v), .alu_carry(alu_carry), .cond_pass(cond_pass), .nzcv(nzcv),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_rd(mem_rd), .mem_wb_en(mem_wb_en)
`ifdef EX_PERF_CNT_EN
    , .perf_exec(perf_exec), .perf_skip(perf_skip)
`endif
  );

  // Stimulus helper: present one instruction in EX
  task automatic set_ex(input logic v, input logic [3:0] cond, input logic s,
                        input logic [3:0] op, input logic wb, input logic [3:0] rd,
                        input logic [31:0] res, input logic [3:0] flags, input logic shc);
    ex_valid = v; ex_cond = cond; ex_s = s; ex_op = op; ex_wb_en = wb; ex_rd = rd;
    alu_s = res; {alu_n, alu_z, alu_c, alu_v} = flags; sh_carry = shc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    set_ex(1'b0, COND_AL, 1'b0, OP_ADD, 1'b0, 4'd0, 32'h0, 4'b0000, 1'b0);
    #12;
    checks++;
    if (nzcv !== 4'b0000 || mem_valid !== 1'b0 || mem_result !== 32'h0 ||
        mem_rd !== 4'd0 || mem_wb_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_state nzcv=%b mv=%b res=%h rd=%h wb=%b required 0000/0/0/0/0",
               nzcv, mem_valid, mem_result, mem_rd, mem_wb_en);
    end
`ifdef EX_PERF_CNT_EN
    checks++;
    if (perf_exec !== 4'd0 || perf_skip !== 4'd0) begin
      failures++;
      $display("FAIL reset_perf exec=%0d skip=%0d required 0/0", perf_exec, perf_skip);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_flags();
    set_ex(1'b1, COND_AL, 1'b1, OP_CMP, 1'b1, 4'd3, 32'h0, 4'b0110, 1'b0);
    step();
    checks++;
    if (nzcv !== 4'b0110 || mem_valid !== 1'b1 || mem_wb_en !== 1'b0 || mem_rd !== 4'd3) begin
      failures++;
      $display("FAIL cmp_flags nzcv=%b mv=%b wb=%b rd=%0d required 0110/1/0/3",
               nzcv, mem_valid, mem_wb_en, mem_rd);
    end
    checks++;
    if (alu_carry !== 1'b1) begin
      failures++;
      $display("FAIL alu_carry got=%b required 1", alu_carry);
    end
    set_ex(1'b1, COND_NE, 1'b0, OP_ADD, 1'b1, 4'd5, 32'h5, 4'b0000, 1'b0);
    #1;
    checks++;
    if (cond_pass !== 1'b0) begin
      failures++;
      $display("FAIL cond_ne got=%b required 0", cond_pass);
    end
    ex_cond = COND_EQ;
    #1;
    checks++;
    if (cond_pass !== 1'b1) begin
      failures++;
      $display("FAIL cond_eq got=%b required 1", cond_pass);
    end
    step();
    checks++;
    if (mem_valid !== 1'b1 || mem_result !== 32'h5 || mem_wb_en !== 1'b1 || mem_rd !== 4'd5) begin
      failures++;
      $display("FAIL eq_exec mv=%b res=%h wb=%b rd=%0d required 1/5/1/5",
               mem_valid, mem_result, mem_wb_en, mem_rd);
    end
  endtask

  task automatic test_logical();
    set_ex(1'b1, COND_AL, 1'b1, OP_CMP, 1'b0, 4'd0, 32'h0, 4'b0011, 1'b0);
    step();
    checks++;
    if (nzcv !== 4'b0011) begin
      failures++;
      $display("FAIL logical_setup nzcv=%b required 0011", nzcv);
    end
    set_ex(1'b1, COND_AL, 1'b1, OP_AND, 1'b1, 4'd1, 32'h1, 4'b0011, 1'b0);
    step();
    checks++;
    if (nzcv !== 4'b0001) begin
      failures++;
      $display("FAIL logical_s nzcv=%b required 0001", nzcv);
    end
  endtask

  task automatic test_skip();
    set_ex(1'b1, COND_AL, 1'b1, OP_CMP, 1'b0, 4'd0, 32'h0, 4'b1000, 1'b0);
    step();
    set_ex(1'b1, COND_GT, 1'b1, OP_ADD, 1'b1, 4'd2, 32'h77, 4'b1111, 1'b1);
    #1;
    checks++;
    if (cond_pass !== 1'b0) begin
      failures++;
      $display("FAIL skip_cond got=%b required 0", cond_pass);
    end
    step();
    checks++;
    if (mem_valid !== 1'b0 || nzcv !== 4'b1000) begin
      failures++;
      $display("FAIL skip_bubble mv=%b nzcv=%b required 0/1000", mem_valid, nzcv);
    end
  endtask

  task automatic test_stall();
    set_ex(1'b1, COND_AL, 1'b0, OP_ADD, 1'b1, 4'd7, 32'hDEADBEEF, 4'b0000, 1'b0);
    step();
    mem_ready = 1'b0;
    set_ex(1'b1, COND_AL, 1'b1, OP_CMP, 1'b1, 4'd9, 32'h1234, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ex_ready !== 1'b0 || mem_valid !== 1'b1 || mem_result !== 32'hDEADBEEF ||
          mem_rd !== 4'd7 || mem_wb_en !== 1'b1 || nzcv !== 4'b1000) begin
        failures++;
        $display("FAIL stall_hold[%0d] rdy=%b mv=%b res=%h rd=%0d wb=%b nzcv=%b required 0/1/deadbeef/7/1/1000",
                 i, ex_ready, mem_valid, mem_result, mem_rd, mem_wb_en, nzcv);
      end
      step();
    end
    mem_ready = 1'b1;
    step();
    checks++;
    if (nzcv !== 4'b1111 || mem_valid !== 1'b1 || mem_wb_en !== 1'b0 || mem_rd !== 4'd9) begin
      failures++;
      $display("FAIL stall_release nzcv=%b mv=%b wb=%b rd=%0d required 1111/1/0/9",
               nzcv, mem_valid, mem_wb_en, mem_rd);
    end
  endtask

  task automatic test_flush_stall();
`ifdef EX_PERF_CNT_EN
    logic [3:0] exec_before;
    exec_before = perf_exec;
`endif
    mem_ready = 1'b0;
    flush = 1'b1;
    set_ex(1'b1, COND_AL, 1'b1, OP_ADD, 1'b1, 4'd4, 32'hAAAA, 4'b0000, 1'b0);
    step();
    flush = 1'b0;
    checks++;
    if (mem_valid !== 1'b0 || mem_wb_en !== 1'b0 || nzcv !== 4'b1111) begin
      failures++;
      $display("FAIL flush_stall mv=%b wb=%b nzcv=%b required 0/0/1111", mem_valid, mem_wb_en, nzcv);
    end
`ifdef EX_PERF_CNT_EN
    checks++;
    if (perf_exec !== exec_before) begin
      failures++;
      $display("FAIL flush_perf got=%0d required %0d", perf_exec, exec_before);
    end
`endif
    mem_ready = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, COND_AL, 1'b0, OP_MOV, 1'b1, 4'(i + 1), vals[i], 4'b0000, 1'b0);
      step();
      checks++;
      if (mem_valid !== 1'b1 || mem_result !== vals[i] || mem_rd !== 4'(i + 1)) begin
        failures++;
        $display("FAIL b2b[%0d] mv=%b res=%h rd=%0d required 1/%h/%0d",
                 i, mem_valid, mem_result, mem_rd, vals[i], i + 1);
      end
    end
  endtask

  task automatic test_mid_reset();
    mem_ready = 1'b0;
    set_ex(1'b0, COND_AL, 1'b0, OP_ADD, 1'b0, 4'd0, 32'h0, 4'b0000, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (nzcv !== 4'b0000 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset nzcv=%b mv=%b required 0000/0", nzcv, mem_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required 1", ex_ready);
    end
    mem_ready = 1'b1;
  endtask

`ifdef EX_PERF_CNT_EN
  task automatic test_perf_wrap();
    step();
    set_ex(1'b1, COND_AL, 1'b0, OP_ADD, 1'b1, 4'd1, 32'h1, 4'b0000, 1'b0);
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (perf_exec !== 4'd15) begin
      failures++;
      $display("FAIL perf_15 got=%0d required 15", perf_exec);
    end
    step();
    checks++;
    if (perf_exec !== 4'd0) begin
      failures++;
      $display("FAIL perf_wrap got=%0d required 0", perf_exec);
    end
    ex_cond = COND_NV;
    step();
    checks++;
    if (perf_skip !== 4'd1 || perf_exec !== 4'd0) begin
      failures++;
      $display("FAIL perf_skip skip=%0d exec=%0d required 1/0", perf_skip, perf_exec);
    end
    ex_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_flags();
    test_logical();
    test_skip();
    test_stall();
    test_flush_stall();
    test_back_to_back();
    test_mid_reset();
`ifdef EX_PERF_CNT_EN
    test_perf_wrap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
